// File: rtl/aes_axis_cmd_framer.sv
// Frames a raw payload packet as cmd / key / IV / payload chunks for the AES AXI-Stream core.
// Optional build macro AES_FRAMER_PAD_EN: zero-pad unaligned packets to a 4-word boundary.
module aes_axis_cmd_framer #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int KEY_WORDS          = 4,
  parameter int IV_WORDS           = 4,
  parameter int MAX_PAYLOAD_WORDS  = 2048
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_aresetn,
  input  logic [31:0]                     cfg_cmd,
  input  logic [32*KEY_WORDS-1:0]         cfg_key,
  input  logic [32*IV_WORDS-1:0]          cfg_iv,
  input  logic                            cfg_key_new,
  input  logic                            cfg_iv_en,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                            s00_axis_tlast,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tlast,
  output logic                            busy,
  output logic                            err_unaligned
);

  localparam int KW = 32 * KEY_WORDS;
  localparam int IW = 32 * IV_WORDS;
  localparam int PW = $clog2(MAX_PAYLOAD_WORDS) + 1;
  localparam int WW = $clog2((KEY_WORDS > IV_WORDS) ? KEY_WORDS : IV_WORDS) + 1;

`ifdef AES_FRAMER_PAD_EN
  typedef enum logic [2:0] {IDLE, CMD, KEY, IV, PAYLOAD, PAD} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, KEY, IV, PAYLOAD} state_t;
`endif

  state_t          state, state_nxt;
  logic [31:0]     cmd_q;
  logic [KW-1:0]   key_sr;
  logic [IW-1:0]   iv_sr;
  logic            iv_en_q, key_pending;
  logic [WW-1:0]   wcnt, wcnt_nxt;
  logic [PW-1:0]   pcnt, pcnt_nxt, pinc;
  logic            err_q, err_nxt;
  logic            latch, key_rot, iv_rot, kp_clr;

  assign pinc           = pcnt + 1'b1;
  assign busy           = (state != IDLE);
  assign err_unaligned  = err_q;
  assign m00_axis_tstrb = '1;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) state <= IDLE;
    else                   state <= state_nxt;
  end

  // Key and IV are rotated rather than shifted so a full pass restores the
  // original order; the IV is resent from the same register in every chunk.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      cmd_q       <= '0;
      key_sr      <= '0;
      iv_sr       <= '0;
      iv_en_q     <= 1'b0;
      key_pending <= 1'b0;
      wcnt        <= '0;
      pcnt        <= '0;
      err_q       <= 1'b0;
    end else begin
      wcnt  <= wcnt_nxt;
      pcnt  <= pcnt_nxt;
      err_q <= err_nxt;
      if (latch) begin
        cmd_q       <= cfg_cmd;
        key_sr      <= cfg_key;
        iv_sr       <= cfg_iv;
        iv_en_q     <= cfg_iv_en;
        key_pending <= cfg_key_new;
      end else begin
        if (kp_clr)  key_pending <= 1'b0;
        if (key_rot) key_sr <= {key_sr[KW-33:0], key_sr[KW-1 -: 32]};
        if (iv_rot)  iv_sr  <= {iv_sr[IW-33:0], iv_sr[IW-1 -: 32]};
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    s00_axis_tready = 1'b0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tdata  = '0;
    m00_axis_tlast  = 1'b0;
    wcnt_nxt        = wcnt;
    pcnt_nxt        = pcnt;
    err_nxt         = 1'b0;
    latch           = 1'b0;
    key_rot         = 1'b0;
    iv_rot          = 1'b0;
    kp_clr          = 1'b0;
    unique case (state)
      IDLE: begin
        if (s00_axis_tvalid) begin
          latch     = 1'b1;
          state_nxt = CMD;
        end
      end
      CMD: begin
        m00_axis_tvalid = 1'b1;
        m00_axis_tdata  = cmd_q;
        pcnt_nxt        = '0;
        wcnt_nxt        = '0;
        if (m00_axis_tready) begin
          if (key_pending)  state_nxt = KEY;
          else if (iv_en_q) state_nxt = IV;
          else              state_nxt = PAYLOAD;
        end
      end
      KEY: begin
        m00_axis_tvalid = 1'b1;
        m00_axis_tdata  = key_sr[KW-1 -: 32];
        if (m00_axis_tready) begin
          key_rot = 1'b1;
          if (wcnt == WW'(KEY_WORDS - 1)) begin
            wcnt_nxt  = '0;
            kp_clr    = 1'b1;
            state_nxt = iv_en_q ? IV : PAYLOAD;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
      end
      IV: begin
        m00_axis_tvalid = 1'b1;
        m00_axis_tdata  = iv_sr[IW-1 -: 32];
        if (m00_axis_tready) begin
          iv_rot = 1'b1;
          if (wcnt == WW'(IV_WORDS - 1)) begin
            wcnt_nxt  = '0;
            state_nxt = PAYLOAD;
          end else begin
            wcnt_nxt = wcnt + 1'b1;
          end
        end
      end
      PAYLOAD: begin
        m00_axis_tvalid = s00_axis_tvalid;
        s00_axis_tready = m00_axis_tready;
        m00_axis_tdata  = s00_axis_tdata;
        // tlast is decoded from the presented word so it stays stable while stalled
        if (s00_axis_tlast) begin
          if (pinc[1:0] == 2'b00) begin
            m00_axis_tlast = 1'b1;
            if (s00_axis_tvalid && m00_axis_tready) begin
              pcnt_nxt  = '0;
              state_nxt = IDLE;
            end
          end else begin
`ifdef AES_FRAMER_PAD_EN
            if (s00_axis_tvalid && m00_axis_tready) begin
              err_nxt   = 1'b1;
              pcnt_nxt  = pinc;
              state_nxt = PAD;
            end
`else
            m00_axis_tlast = 1'b1;
            if (s00_axis_tvalid && m00_axis_tready) begin
              err_nxt   = 1'b1;
              pcnt_nxt  = '0;
              state_nxt = IDLE;
            end
`endif
          end
        end else if (pinc == PW'(MAX_PAYLOAD_WORDS)) begin
          m00_axis_tlast = 1'b1;
          if (s00_axis_tvalid && m00_axis_tready) begin
            pcnt_nxt  = '0;
            state_nxt = CMD;
          end
        end else if (s00_axis_tvalid && m00_axis_tready) begin
          pcnt_nxt = pinc;
        end
      end
`ifdef AES_FRAMER_PAD_EN
      PAD: begin
        m00_axis_tvalid = 1'b1;
        m00_axis_tlast  = (pinc[1:0] == 2'b00);
        if (m00_axis_tready) begin
          if (pinc[1:0] == 2'b00) begin
            pcnt_nxt  = '0;
            state_nxt = IDLE;
          end else begin
            pcnt_nxt = pinc;
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_axis_cmd_framer.sv
// Scoreboard bench for aes_axis_cmd_framer (chunk size 8); expectations follow AES_FRAMER_PAD_EN.
module tb_aes_axis_cmd_framer;

  localparam int MAXW = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  cfg_cmd = '0;
  logic [127:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         cfg_key_new = 1'b0, cfg_iv_en = 1'b0;
  logic         s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [31:0]  s_tdata = '0;
  logic         m_tvalid, m_tready = 1'b1, m_tlast;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tstrb;
  logic         busy, err_unaligned;

  aes_axis_cmd_framer #(
    .C_AXIS_TDATA_WIDTH(32),
    .KEY_WORDS(4),
    .IV_WORDS(4),
    .MAX_PAYLOAD_WORDS(MAXW)
  ) dut (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .cfg_cmd(cfg_cmd), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .cfg_key_new(cfg_key_new), .cfg_iv_en(cfg_iv_en),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_tready),
    .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready),
    .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb), .m00_axis_tlast(m_tlast),
    .busy(busy), .err_unaligned(err_unaligned)
  );

  always #5 clk = ~clk;

  logic [127:0] key_v = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
  logic [127:0] iv_v  = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;

  logic [32:0] exp_q[$];
  int checks = 0, errors = 0;
  int err_seen = 0, exp_err = 0;
  int cyc = 0, first_cyc = -1, last_cyc = -1;
  bit sb_on = 1'b1, rand_rdy = 1'b0, held_valid = 1'b0;
  logic [32:0] held_word = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    logic [32:0] e;
    cyc++;
    if (!rst_n || !sb_on) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid)
        check_eq("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, held_word});
      if (!m_tready)
        check_eq("s00_rdy_stall", s_tready, 1'b0);
      if (m_tvalid && m_tready) begin
        check_eq("q_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("tdata", m_tdata, e[31:0]);
          check_eq("tlast", m_tlast, e[32]);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      held_valid = m_tvalid && !m_tready;
      held_word  = {m_tlast, m_tdata};
      if (err_unaligned) err_seen++;
    end
  end

  // Independent frame model: chunking, key only in the first chunk, IV every chunk, padding.
  task automatic expect_pkt(input logic [31:0] cmd, input bit key_new, input bit iv_en,
                            input int n, input logic [31:0] base);
    bit first = 1'b1, done = 1'b0;
    int idx = 0, cnt;
    logic [31:0] w;
    while (!done) begin
      exp_q.push_back({1'b0, cmd});
      if (first && key_new)
        for (int k = 3; k >= 0; k--) exp_q.push_back({1'b0, key_v[k*32 +: 32]});
      if (iv_en)
        for (int k = 3; k >= 0; k--) exp_q.push_back({1'b0, iv_v[k*32 +: 32]});
      first = 1'b0;
      cnt = 0;
      while (1) begin
        w = base + 32'(idx);
        idx++;
        cnt++;
        if (idx == n) begin
          done = 1'b1;
          if (cnt % 4 == 0) exp_q.push_back({1'b1, w});
          else begin
            exp_err++;
`ifdef AES_FRAMER_PAD_EN
            exp_q.push_back({1'b0, w});
            while (cnt % 4 != 0) begin
              cnt++;
              exp_q.push_back({cnt % 4 == 0, 32'h0});
            end
`else
            exp_q.push_back({1'b1, w});
`endif
          end
          break;
        end else if (cnt == MAXW) begin
          exp_q.push_back({1'b1, w});
          break;
        end else begin
          exp_q.push_back({1'b0, w});
        end
      end
    end
  endtask

  task automatic send_pkt(input logic [31:0] cmd, input bit key_new, input bit iv_en,
                          input int n, input logic [31:0] base);
    bit acc;
    cfg_cmd = cmd; cfg_key = key_v; cfg_iv = iv_v;
    cfg_key_new = key_new; cfg_iv_en = iv_en;
    expect_pkt(cmd, key_new, iv_en, n, base);
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = base + 32'(i);
      s_tlast  = (i == n - 1);
      acc = 1'b0;
      for (int t = 0; t < 500 && !acc; t++) begin
        @(negedge clk);
        acc = s_tvalid && s_tready;
        @(posedge clk);
        #1;
      end
      check_eq("s00_accept", acc, 1'b1);
      if (!acc) break;
      if (i == 0) begin
        // Mid-frame config changes must be ignored
        cfg_cmd = ~cmd; cfg_key = ~key_v; cfg_iv = ~iv_v;
        cfg_key_new = ~key_new; cfg_iv_en = ~iv_en;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(negedge clk);
    check_eq({tag, "_drain"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
    check_eq({tag, "_err_cnt"}, err_seen, exp_err);
    check_eq({tag, "_idle"}, busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_s_tready", s_tready, 1'b0);
    check_eq("rst_m_tvalid", m_tvalid, 1'b0);
    check_eq("rst_m_tdata", m_tdata, 32'h0);
    check_eq("rst_m_tlast", m_tlast, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", err_unaligned, 1'b0);
    check_eq("tstrb", m_tstrb, 4'hF);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    first_cyc = -1;
    send_pkt(32'hC0DE0001, 1'b1, 1'b1, 8, 32'h1);
    wait_drain("s1");
    check_eq("s1_no_bubble", last_cyc - first_cyc, 16);

    send_pkt(32'hC0DE0002, 1'b0, 1'b0, 4, 32'h100);
    wait_drain("s2");
    send_pkt(32'hC0DE0003, 1'b1, 1'b1, 12, 32'h200);
    wait_drain("s3");
    send_pkt(32'hC0DE0004, 1'b0, 1'b1, 6, 32'h300);
    wait_drain("s4");
    send_pkt(32'hC0DE0005, 1'b1, 1'b0, 16, 32'h400);
    wait_drain("s16");

    rand_rdy = 1'b1;
    send_pkt(32'hC0DE0001, 1'b1, 1'b1, 8, 32'h1);
    wait_drain("s5");
    send_pkt(32'hC0DE0006, 1'b1, 1'b1, 13, 32'h500);
    wait_drain("s5b");
    send_pkt(32'hC0DE0007, 1'b0, 1'b0, 5, 32'h600);
    wait_drain("s5c");
    rand_rdy = 1'b0;
    @(posedge clk); #1;

    // Reset while the second key word is on the bus
    sb_on = 1'b0;
    cfg_cmd = 32'hDEAD0000; cfg_key = key_v; cfg_iv = iv_v;
    cfg_key_new = 1'b1; cfg_iv_en = 1'b1;
    s_tvalid = 1'b1; s_tdata = 32'h777; s_tlast = 1'b0;
    for (int t = 0; t < 20 && !busy; t++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_eq("mid_key_word", m_tdata, key_v[95:64]);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst6_m_tvalid", m_tvalid, 1'b0);
    check_eq("rst6_busy", busy, 1'b0);
    check_eq("rst6_m_tlast", m_tlast, 1'b0);
    s_tvalid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb_on = 1'b1;
    @(posedge clk); #1;
    send_pkt(32'hC0DE0008, 1'b0, 1'b0, 4, 32'h700);
    wait_drain("s6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
